// File: rtl/led_count_sequencer_pkg.sv
// Shared types and defaults for the LED count sequencer.
// FSM states plus default prescaler and counter sizing.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam int TICK_DIV_DEF = 25_000_000;
  localparam int WIDTH_DEF    = 8;

endpackage

// File: rtl/led_count_sequencer_if.sv
// Front-panel control and LED status bundle.
// master drives the controls, slave is the sequencer.
interface led_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             stop;
  logic             step;
  logic             oneshot;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] ld;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output start, stop, step,
    output oneshot, dir, limit,
    input  ld, busy, done, tick
  );

  modport slave (
    input  start, stop, step,
    input  oneshot, dir, limit,
    output ld, busy, done, tick
  );

endinterface

// File: rtl/led_count_sequencer_tick_prescaler.sv
// One-cycle count enable from a free divider on clk.
// restart re-arms the count; en gates it.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  // divider count and registered terminal pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_count_sequencer.sv
// Run/pause/step/terminate sequencer for the LED counter.
// Single clock domain; the prescaler only supplies an enable.
module led_count_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input logic    clk,
  input logic    clr,
  led_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] lim_q;
  logic             dir_q;
  logic             os_q;
  logic             busy_q;
  logic             done_q;

  logic             tick;
  logic             run;
  logic             load;
  logic             resume;
  logic             restart;
  logic             en;
  logic             at_end;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] nxt;

  assign run    = (state == RUN);
  assign load   = bus.start &&
                  (state == IDLE || state == DONE);
  assign resume = bus.start && (state == PAUSE);

  // each applied tick re-arms the divider, so ticks
  // land TICK_DIV+1 apart, same spacing as after start
  assign restart = load | resume | (run & tick);

  // freeze on the stop edge so no tick leaks into PAUSE
  assign en = run & ~bus.stop;

  assign end_val   = dir_q ? '0 : lim_q;
  assign start_val = dir_q ? lim_q : '0;
  assign at_end    = (ld_q == end_val);
  assign nxt       = at_end ? start_val :
                     dir_q  ? ld_q - ONE :
                              ld_q + ONE;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_pre (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  // sequencer state, latched config and LED count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      ld_q   <= '0;
      lim_q  <= '0;
      dir_q  <= 1'b0;
      os_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            lim_q  <= bus.limit;
            dir_q  <= bus.dir;
            os_q   <= bus.oneshot;
            ld_q   <= bus.dir ? bus.limit : '0;
            state  <= RUN;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (tick && at_end && os_q) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            if (tick) ld_q <= nxt;
            if (bus.stop) begin
              state  <= PAUSE;
              busy_q <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else if (bus.step) begin
            if (at_end && os_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              ld_q <= nxt;
            end
          end
        end
      endcase
    end
  end

  assign bus.ld   = ld_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tick = tick;

endmodule
